passcode_entry: RTL and testbench
=================================

PASSCODE_ENTRY -- requirements
Module: passcode_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of decimal digits in a code.
REQ-002 SHALL have parameter MAX_TRIES, default 3: failed submits allowed before lockout.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clk cycles.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port clr  input  1  reset: clr, asynchronous, active-high.
REQ-006 SHALL have port key_valid  input  1  one-cycle pulse, key holds a pressed digit.
REQ-007 SHALL have port key  input  4  BCD digit 0-9.
REQ-008 SHALL have port submit  input  1  one-cycle pulse, check the entered code (or relock when open).
REQ-009 SHALL have port secret  input  4*DIGITS  stored code; digit 0 in bits [3:0].
REQ-010 SHALL have port entry_en  output  DIGITS  one-hot write enable to the downstream per-digit register bank.
REQ-011 SHALL have port entry_d  output  4  digit data to the downstream register bank.
REQ-012 SHALL have port entry_clr  output  1  one-cycle pulse clearing the downstream register bank.
REQ-013 SHALL have port unlocked  output  1  high while in OPEN.
REQ-014 SHALL have port fail  output  1  one-cycle pulse on a wrong code.
REQ-015 SHALL have port locked_out  output  1  high while in LOCKOUT.
REQ-016 SHALL have port tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts.

Function
REQ-017 SHALL implement registered states IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
REQ-018 SHALL hold an internal digit buffer (4*DIGITS bits) and digit count cnt (0..DIGITS).
REQ-019 IDLE: a key_valid with key<=9 SHALL store the digit at index 0, set cnt=1, and go to ENTRY.
REQ-020 ENTRY: a key_valid with key<=9 and cnt<DIGITS SHALL store the digit at index cnt and increment cnt; with cnt==DIGITS the key SHALL be ignored.
REQ-021 Keys with value 10-15 SHALL be ignored in all states.
REQ-022 Each accepted digit SHALL produce entry_en[index]=1 and entry_d=digit on the cycle after acceptance, for exactly one cycle; otherwise entry_en=0.
REQ-023 A submit in ENTRY SHALL go to CHECK; a submit in IDLE SHALL be ignored.
REQ-024 If key_valid and submit coincide, submit SHALL win and the key SHALL be ignored.
REQ-025 CHECK SHALL last one cycle and go to OPEN if cnt==DIGITS and buffer==secret, else to FAIL; a short entry SHALL count as a mismatch.
REQ-026 OPEN: unlocked=1; tries_left SHALL reload MAX_TRIES on entry; submit SHALL go to IDLE; keys SHALL be ignored.
REQ-027 FAIL SHALL last one cycle with fail=1 and decrement tries_left; it SHALL go to LOCKOUT if the decremented value is 0, else to IDLE.
REQ-028 LOCKOUT: locked_out=1 and all inputs ignored for exactly LOCK_CYCLES cycles; it SHALL then go to IDLE and reload tries_left=MAX_TRIES.
REQ-029 Every transition into IDLE SHALL pulse entry_clr for one cycle and zero the buffer and cnt.
REQ-030 Latency: with submit sampled at edge N, unlocked or fail SHALL be high after edge N+2.
REQ-031 secret SHALL be sampled only in CHECK; changes to it at other times SHALL have no effect.

Reset
REQ-032 clr=1 SHALL immediately force IDLE, buffer=0, cnt=0, tries_left=MAX_TRIES, lockout counter=0, and all other outputs 0, including during an operation in progress.
REQ-033 After clr deasserts, the first key_valid SHALL be accepted on the next rising edge.

Verification
REQ-034 secret=16'h4321, keys 1,2,3,4, submit -> entry_en pulses 0001, 0010, 0100, 1000 with entry_d 1,2,3,4; unlocked=1 two edges after submit.
REQ-035 Keys 1,2,3,5, submit -> fail pulses once, tries_left 3->2, entry_clr pulses, state returns to IDLE.
REQ-036 Three wrong codes -> locked_out=1 for 16 cycles with keys ignored; then tries_left=3 and IDLE.
REQ-037 Keys 1,2 then submit -> fail; keys 1,2,3,4,9 then submit -> 9 ignored and unlocked=1.
REQ-038 key=4'hA pulses, plus key_valid coinciding with submit -> no entry_en asserted for either.
REQ-039 clr pulsed mid-entry and during LOCKOUT -> all outputs 0 and tries_left=3 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/passcode_entry.sv
// Passcode entry controller.
// Collects up to DIGITS decimal key presses, mirrors each accepted digit to a
// downstream per-digit register bank, and compares the entry against `secret`
// on submit. Repeated wrong codes lead to a timed lockout.
// Status outputs (unlocked, fail, locked_out) are registered from the state
// register, so they follow the state by one cycle. A submit sampled at edge N
// therefore shows unlocked/fail after edge N+2.
module passcode_entry #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           key_valid,
  input  logic [3:0]                     key,
  input  logic                           submit,
  input  logic [4*DIGITS-1:0]            secret,
  output logic [DIGITS-1:0]              entry_en,
  output logic [3:0]                     entry_d,
  output logic                           entry_clr,
  output logic                           unlocked,
  output logic                           fail,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] digit_buf;
  logic [CW-1:0]       cnt;
  logic [LW-1:0]       lock_cnt;

  // A key is usable only if it is a BCD digit and no submit competes with it.
  logic key_ok;
  assign key_ok = key_valid && !submit && (key <= 4'd9);

  // Controller state, digit buffer, counters and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_IDLE;
      // NOTE: the digit buffer is a handful of flops, not a RAM, so it is
      // cleared by reset like any other state; a stale code must never survive.
      digit_buf  <= '0;
      cnt        <= '0;
      lock_cnt   <= '0;
      entry_en   <= '0;
      entry_d    <= '0;
      entry_clr  <= 1'b0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
      tries_left <= TW'(MAX_TRIES);
    end else begin
      // NOTE: every assignment here is non-blocking, so all right-hand sides
      // see the pre-edge values; defaults below are overridden later in the
      // same block by the case arms.
      entry_en   <= '0;
      entry_d    <= '0;
      entry_clr  <= 1'b0;
      unlocked   <= (state == S_OPEN);
      fail       <= (state == S_FAIL);
      locked_out <= (state == S_LOCKOUT);

      case (state)
        S_IDLE: begin
          if (key_ok) begin
            digit_buf[3:0] <= key;
            cnt            <= CW'(1);
            entry_en       <= DIGITS'(1);
            entry_d        <= key;
            state          <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (submit) begin
            state <= S_CHECK;
          end else if (key_ok && (cnt < CW'(DIGITS))) begin
            digit_buf[int'(cnt)*4 +: 4] <= key;
            cnt                         <= cnt + CW'(1);
            entry_en                    <= DIGITS'(1) << cnt;
            entry_d                     <= key;
          end
        end

        S_CHECK: begin
          if ((cnt == CW'(DIGITS)) && (digit_buf == secret)) begin
            state      <= S_OPEN;
            tries_left <= TW'(MAX_TRIES);
          end else begin
            state <= S_FAIL;
          end
        end

        S_OPEN: begin
          if (submit) begin
            state     <= S_IDLE;
            digit_buf <= '0;
            cnt       <= '0;
            entry_clr <= 1'b1;
          end
        end

        S_FAIL: begin
          tries_left <= tries_left - TW'(1);
          if (tries_left == TW'(1)) begin
            state    <= S_LOCKOUT;
            lock_cnt <= '0;
          end else begin
            state     <= S_IDLE;
            digit_buf <= '0;
            cnt       <= '0;
            entry_clr <= 1'b1;
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            state      <= S_IDLE;
            lock_cnt   <= '0;
            digit_buf  <= '0;
            cnt        <= '0;
            entry_clr  <= 1'b1;
            tries_left <= TW'(MAX_TRIES);
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          digit_buf <= '0;
          cnt       <= '0;
          entry_clr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_entry.sv
// Directed bench for passcode_entry: a vector table for the main flows plus
// hand-written sequences for lockout and asynchronous clear.
module tb_passcode_entry;

  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'd0;
  logic        submit = 1'b0;
  logic [15:0] secret = 16'h4321;
  logic [3:0]  entry_en;
  logic [3:0]  entry_d;
  logic        entry_clr;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  logic [1:0]  tries_left;

  int errors = 0;
  int checks = 0;

  passcode_entry #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key(key), .submit(submit),
    .secret(secret), .entry_en(entry_en), .entry_d(entry_d),
    .entry_clr(entry_clr), .unlocked(unlocked), .fail(fail),
    .locked_out(locked_out), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [3:0] k;
    logic       sub;
    logic [3:0] en;
    logic [3:0] d;
    logic       unl;
    logic       fl;
    logic       lk;
    logic       cl;
    logic [1:0] tr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic kv, input logic [3:0] k, input logic s);
    key_valid = kv;
    key       = k;
    submit    = s;
  endtask

  task automatic check_all(input string tag, input logic [3:0] en, input logic unl,
                           input logic fl, input logic lk, input logic cl,
                           input logic [1:0] tr);
    check({tag, ".entry_en"},   entry_en,   en);
    check({tag, ".unlocked"},   unlocked,   unl);
    check({tag, ".fail"},       fail,       fl);
    check({tag, ".locked_out"}, locked_out, lk);
    check({tag, ".entry_clr"},  entry_clr,  cl);
    check({tag, ".tries_left"}, tries_left, tr);
  endtask

  function automatic vec_t mk(logic kv, logic [3:0] k, logic sub, logic [3:0] en,
                              logic [3:0] d, logic unl, logic fl, logic lk,
                              logic cl, logic [1:0] tr);
    vec_t v;
    v.kv = kv; v.k = k; v.sub = sub; v.en = en; v.d = d;
    v.unl = unl; v.fl = fl; v.lk = lk; v.cl = cl; v.tr = tr;
    return v;
  endfunction

  // One wrong code (single digit, then submit); checks the fail pulse.
  task automatic wrong_code(input logic [1:0] exp_tries, input logic exp_clr);
    drive(1'b1, 4'd1, 1'b0); step();
    drive(1'b0, 4'd0, 1'b1); step();
    drive(1'b0, 4'd0, 1'b0); step();
    step();
    check("wrong.fail",       fail,       1'b1);
    check("wrong.tries_left", tries_left, exp_tries);
    check("wrong.entry_clr",  entry_clr,  exp_clr);
  endtask

  initial begin
    int hi;
    bit exited;
    bit leak;

    //           kv  key  sub  en      d    unl fl lk cl tr
    // Correct code 1,2,3,4 then open and relock.
    vecs.push_back(mk(1, 4'd1, 0, 4'b0001, 4'd1, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd2, 0, 4'b0010, 4'd2, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd3, 0, 4'b0100, 4'd3, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd4, 0, 4'b1000, 4'd4, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(0, 4'd0, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3)); // -> CHECK
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3)); // -> OPEN
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 1, 0, 0, 0, 2'd3)); // submit+2
    vecs.push_back(mk(1, 4'd7, 0, 4'b0000, 4'd0, 1, 0, 0, 0, 2'd3)); // key in OPEN
    vecs.push_back(mk(0, 4'd0, 1, 4'b0000, 4'd0, 1, 0, 0, 1, 2'd3)); // relock
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3));
    // Wrong code 1,2,3,5.
    vecs.push_back(mk(1, 4'd1, 0, 4'b0001, 4'd1, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd2, 0, 4'b0010, 4'd2, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd3, 0, 4'b0100, 4'd3, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(1, 4'd5, 0, 4'b1000, 4'd5, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(0, 4'd0, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 1, 0, 1, 2'd2)); // fail pulse
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2));
    // Non-BCD keys and key+submit in IDLE are all ignored.
    vecs.push_back(mk(1, 4'hA, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(1, 4'hF, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(1, 4'd1, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2));
    // Short entry 1,2 with a key coinciding with submit -> fail.
    vecs.push_back(mk(1, 4'd1, 0, 4'b0001, 4'd1, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(1, 4'hC, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2)); // ignored in ENTRY
    vecs.push_back(mk(1, 4'd2, 0, 4'b0010, 4'd2, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(1, 4'd3, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2)); // submit wins
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 1, 0, 1, 2'd1));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd1));
    // 1,2,3,4,9: fifth digit ignored, code opens, tries reload.
    vecs.push_back(mk(1, 4'd1, 0, 4'b0001, 4'd1, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 4'd2, 0, 4'b0010, 4'd2, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 4'd3, 0, 4'b0100, 4'd3, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 4'd4, 0, 4'b1000, 4'd4, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 4'd9, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd1)); // buffer full
    vecs.push_back(mk(0, 4'd0, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3)); // reload on OPEN
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 1, 0, 0, 0, 2'd3));
    vecs.push_back(mk(0, 4'd0, 1, 4'b0000, 4'd0, 1, 0, 0, 1, 2'd3));
    vecs.push_back(mk(0, 4'd0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 2'd3));

    // Reset state, asserted asynchronously away from any clock edge.
    #1 clr = 1'b1;
    #1 check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    step();
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].kv, vecs[i].k, vecs[i].sub);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].unl, vecs[i].fl,
                vecs[i].lk, vecs[i].cl, vecs[i].tr);
      if (vecs[i].en != 4'b0000)
        check($sformatf("vec%0d.entry_d", i), entry_d, vecs[i].d);
    end

    // Three wrong codes -> lockout for LOCK_CYCLES cycles, inputs ignored.
    wrong_code(2'd2, 1'b1);
    step();
    wrong_code(2'd1, 1'b1);
    step();
    wrong_code(2'd0, 1'b0);
    hi = 0; exited = 1'b0; leak = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 4'd1, i[0]);
      step();
      if (locked_out) hi++;
      if (entry_en != 4'b0000) leak = 1'b1;
      if (entry_clr) begin
        exited = 1'b1;
        break;
      end
    end
    drive(1'b0, 4'd0, 1'b0);
    check("lockout.exit_seen",   exited,     1'b1);
    check("lockout.cycles_high", hi,         LOCK_CYCLES);
    check("lockout.keys_leaked", leak,       1'b0);
    check("lockout.tries_left",  tries_left, 2'd3);
    step();
    check("post_lockout.locked_out", locked_out, 1'b0);
    drive(1'b1, 4'd9, 1'b0);
    step();
    check("post_lockout.entry_en", entry_en, 4'b0001);
    check("post_lockout.entry_d",  entry_d,  4'd9);

    // Clear mid-entry: outputs drop without a clock edge.
    drive(1'b1, 4'd2, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("mid_entry.entry_en_before", entry_en, 4'b0010);
    #1 clr = 1'b1;
    #1 check_all("clr_mid_entry", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    step();
    clr = 1'b0;

    // Clear during lockout.
    wrong_code(2'd2, 1'b1);
    step();
    wrong_code(2'd1, 1'b1);
    step();
    wrong_code(2'd0, 1'b0);
    repeat (5) step();
    check("lockout2.locked_out_before", locked_out, 1'b1);
    #1 clr = 1'b1;
    #1 check_all("clr_lockout", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    // First key after clr release is accepted on the next edge.
    drive(1'b1, 4'd5, 1'b0);
    clr = 1'b0;
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("after_clr.entry_en", entry_en, 4'b0001);
    check("after_clr.entry_d",  entry_d,  4'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
